mips_alu: RTL and testbench



---
 rtl/mips_alu.sv | 66 ++++++
 tb/tb_mips_alu.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mips_alu.sv
// Registered 32-bit MIPS integer ALU: AND/OR/ADD/SUB/SLT/NOR with Zero and
// signed Overflow flags, all outputs registered with one cycle of latency.
module mips_alu (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  ALUctl,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] ALUOut,
    output logic        Zero,
    output logic        Overflow
);

    localparam logic [3:0] CTL_AND = 4'd0;
    localparam logic [3:0] CTL_OR  = 4'd1;
    localparam logic [3:0] CTL_ADD = 4'd2;
    localparam logic [3:0] CTL_SUB = 4'd6;
    localparam logic [3:0] CTL_SLT = 4'd7;
    localparam logic [3:0] CTL_NOR = 4'd12;

    // No handshake: a new operation is accepted on every rising edge.
    logic [31:0] sum;
    logic [31:0] diff;
    logic [31:0] result;
    logic        ovf;

    assign sum  = A + B;
    assign diff = A - B;

    always_comb begin
        result = 32'd0;
        ovf    = 1'b0;
        case (ALUctl)
            CTL_AND: result = A & B;
            CTL_OR:  result = A | B;
            CTL_ADD: begin
                result = sum;
                ovf    = (A[31] == B[31]) && (sum[31] != A[31]);
            end
            CTL_SUB: begin
                result = diff;
                ovf    = (A[31] != B[31]) && (diff[31] != A[31]);
            end
            // Signed compare, not the sign of A-B, so overflow cannot flip it.
            CTL_SLT: result = ($signed(A) < $signed(B)) ? 32'd1 : 32'd0;
            CTL_NOR: result = ~(A | B);
            default: begin
                result = 32'd0;
                ovf    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ALUOut   <= 32'd0;
            Zero     <= 1'b1;
            Overflow <= 1'b0;
        end else begin
            ALUOut   <= result;
            Zero     <= (result == 32'd0);
            Overflow <= ovf;
        end
    end

endmodule

// File: tb/tb_mips_alu.sv
// Self-checking bench for mips_alu: directed vectors plus random operations,
// expected results queued at drive time and compared after each edge.
module tb_mips_alu;

    logic        clk;
    logic        reset;
    logic [3:0]  ALUctl;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] ALUOut;
    logic        Zero;
    logic        Overflow;

    int tests_run    = 0;
    int tests_failed = 0;

    // Expected {Overflow, Zero, ALUOut}
    logic [33:0] exp_q[$];

    mips_alu dut (
        .clk      (clk),
        .reset    (reset),
        .ALUctl   (ALUctl),
        .A        (A),
        .B        (B),
        .ALUOut   (ALUOut),
        .Zero     (Zero),
        .Overflow (Overflow)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [33:0] model(input logic rst, input logic [3:0] ctl,
                                          input logic [31:0] a, input logic [31:0] b);
        logic [32:0] wide;
        logic [31:0] r;
        logic        v;
        longint      sa, sb;
        r  = 32'd0;
        v  = 1'b0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (rst) return {1'b0, 1'b1, 32'd0};
        case (ctl)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd2: begin
                wide = {a[31], a} + {b[31], b};
                r = wide[31:0];
                v = wide[32] ^ wide[31];
            end
            4'd6: begin
                wide = {a[31], a} - {b[31], b};
                r = wide[31:0];
                v = wide[32] ^ wide[31];
            end
            4'd7:  r = (sa < sb) ? 32'd1 : 32'd0;
            4'd12: r = ~(a | b);
            default: begin
                r = 32'd0;
                v = 1'b0;
            end
        endcase
        return {v, (r == 32'd0), r};
    endfunction

    // ---------------- driver + scoreboard ----------------
    task automatic drive(input logic rst, input logic [3:0] ctl,
                         input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        reset  = rst;
        ALUctl = ctl;
        A      = a;
        B      = b;
        exp_q.push_back(model(rst, ctl, a, b));
        // Mid-cycle change after the push must not affect the registered result.
        #2;
        A = ~a;
        #1;
        A = a;
        @(posedge clk);
        #1;
        compare($sformatf("ctl%0d a=%h b=%h rst=%0d", ctl, a, b, rst));
    endtask

    task automatic compare(input string tag);
        logic [33:0] e;
        if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL %s: scoreboard empty", tag);
            return;
        end
        e = exp_q.pop_front();
        check({tag, " result"},   ALUOut,             e[31:0]);
        check({tag, " zero"},     {31'd0, Zero},      {31'd0, e[32]});
        check({tag, " overflow"}, {31'd0, Overflow},  {31'd0, e[33]});
    endtask

    // ---------------- stimulus ----------------
    logic [3:0] sweep_ctl[6] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12};
    logic [3:0] legal_ctl[6] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12};

    initial begin
        reset  = 1'b1;
        ALUctl = 4'd0;
        A      = 32'd0;
        B      = 32'd0;

        // Reset with an ADD pending, then released
        drive(1'b1, 4'd2, 32'hA, 32'h5);
        drive(1'b0, 4'd2, 32'hA, 32'h5);

        // Basic sweep
        foreach (sweep_ctl[i]) drive(1'b0, sweep_ctl[i], 32'hA, 32'h5);

        // Signed SLT
        drive(1'b0, 4'd7, 32'hFFFFFFFF, 32'h1);
        drive(1'b0, 4'd7, 32'h1, 32'hFFFFFFFF);
        drive(1'b0, 4'd7, 32'h55, 32'h55);

        // Overflow
        drive(1'b0, 4'd2, 32'h7FFFFFFF, 32'h1);
        drive(1'b0, 4'd6, 32'h80000000, 32'h1);
        drive(1'b0, 4'd7, 32'h80000000, 32'h1);
        drive(1'b0, 4'd2, 32'h80000000, 32'h80000000);
        drive(1'b0, 4'd6, 32'h7FFFFFFF, 32'hFFFFFFFF);

        // Zero / wrap-around
        drive(1'b0, 4'd2, 32'hFFFFFFFF, 32'h1);
        drive(1'b0, 4'd6, 32'h1234, 32'h1234);

        // Illegal codes
        drive(1'b0, 4'd3, 32'hDEADBEEF, 32'h12345678);
        drive(1'b0, 4'd15, 32'h7FFFFFFF, 32'h7FFFFFFF);

        // Reset mid-stream during an overflowing ADD, then resume
        drive(1'b0, 4'd2, 32'h100, 32'h23);
        drive(1'b1, 4'd2, 32'h7FFFFFFF, 32'h7FFFFFFF);
        drive(1'b0, 4'd12, 32'h0F0F0F0F, 32'h00FF00FF);

        // Random operations, occasional illegal code
        for (int n = 0; n < 200; n++) begin
            logic [3:0]  c;
            logic [31:0] a, b;
            c = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15))
                                           : legal_ctl[$urandom_range(0, 5)];
            a = $urandom();
            b = ($urandom_range(0, 7) == 0) ? a : $urandom();
            if ($urandom_range(0, 3) == 0) a[31:30] = 2'b10;
            drive(1'b0, c, a, b);
        end

        if (exp_q.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL scoreboard drain: %0d entries left, 0 expected", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
